div_wb_sched: RTL
=================

DIV_WB_SCHED -- requirements
Module: div_wb_sched

Interface
REQ-001 Parameters: WIDTH, default 64, operand/result width; ID_W, default 3, scoreboard ID width; DEPTH, default 2, request queue entries (>=1); STARVE_MAX, default 4, divider-result wait cycles before mul_stall_o.
REQ-002 clk_i  in  1  clock; all state on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 flush_i  in  1  pipeline flush; kills all queued, in-flight and pending divide work.
REQ-005 req_vld_i / req_rdy_o  in/out  1/1  issue-side divide request handshake.
REQ-006 req_id_i  in  ID_W; req_op_a_i, req_op_b_i  in  WIDTH; req_opcode_i  in  2  (0 udiv, 1 div, 2 urem, 3 rem).
REQ-007 div_vld_o / div_rdy_i  out/in  1/1  dispatch handshake to serial divider (divider configured with stable input handshake).
REQ-008 div_id_o  out  ID_W; div_op_a_o, div_op_b_o  out  WIDTH; div_opcode_o  out  2  head-of-queue fields.
REQ-009 div_flush_o  out  1  equals flush_i combinationally.
REQ-010 div_out_vld_i / div_out_rdy_o  in/out  1/1; div_id_i  in  ID_W; div_res_i  in  WIDTH  divider result.
REQ-011 mul_vld_i  in  1; mul_id_i  in  ID_W; mul_res_i  in  WIDTH  multiplier result, no backpressure.
REQ-012 wb_vld_o  out  1; wb_id_o  out  ID_W; wb_res_o  out  WIDTH  shared writeback port, registered.
REQ-013 mul_stall_o  out  1  registered; asks issue stage to stop issuing multiplies.
REQ-014 busy_o  out  1  any divide work queued, in flight, or awaiting writeback.

Function
REQ-015 Queue: DEPTH-entry FIFO of {id, op_a, op_b, opcode}; count width clog2(DEPTH+1); pointers wrap modulo DEPTH.
REQ-016 req_rdy_o = ~full & ~flush_i; enqueue on req_vld_i & req_rdy_o; no bypass when full even if dispatch occurs same cycle.
REQ-017 Enqueue and dispatch in same cycle: count unchanged, both take effect.
REQ-018 Dispatch FSM states: D_IDLE (no op in divider), D_RUN (one op in divider); at most one divide outstanding.
REQ-019 D_IDLE: div_vld_o = ~empty & ~flush_i; on div_vld_o & div_rdy_i pop head, go D_RUN.
REQ-020 Latency: request accepted cycle N into empty queue, D_IDLE -> div_vld_o asserted cycle N+1.
REQ-021 D_RUN: div_vld_o = 0; div_out_rdy_o = ~mul_vld_i & ~flush_i; on div_out_vld_i & div_out_rdy_o go D_IDLE.
REQ-022 Writeback arbitration, fixed priority: mul_vld_i wins; else accepted divider result.
REQ-023 Winner registered: cycle after mul_vld_i=1 -> wb_vld_o=1, wb_id_o=mul_id_i, wb_res_o=mul_res_i; cycle after divider handshake -> div_id_i/div_res_i; else wb_vld_o=0.
REQ-024 wb_vld_o never asserted for a divider result that did not complete handshake; flush does not suppress a multiplier writeback.
REQ-025 Starvation counter: increments each cycle div_out_vld_i=1 & div_out_rdy_o=0 in D_RUN, saturates at STARVE_MAX, clears on divider handshake or flush.
REQ-026 mul_stall_o registered = (counter == STARVE_MAX); deasserts cycle after divider handshake.
REQ-027 flush_i: next cycle queue empty, FSM D_IDLE, counter 0; divider result present in flush cycle not accepted, not written back.
REQ-028 busy_o = ~empty | (state==D_RUN) | (wb_vld_o & wb from divider).

Reset
REQ-029 While rst_ni=0: queue empty, FSM D_IDLE, counter 0, wb_vld_o=0, wb_id_o=0, wb_res_o=0, mul_stall_o=0, busy_o=0, div_vld_o=0, req_rdy_o=1 after release.
REQ-030 Reset mid-operation discards all queued/in-flight work; no writeback of pre-reset results after release.

Verification
REQ-031 udiv id=2, a=100, b=7, no mul traffic -> div_vld_o cycle after accept; wb_vld_o=1, wb_id_o=2, wb_res_o=14 cycle after divider result.
REQ-032 rem id=5, a=-7, b=2, mul_vld_i=1 id=1 same cycle divider result valid -> wb mul id=1 first; divider result (-1) written back next free cycle.
REQ-033 DEPTH=2: three back-to-back requests ids 0,1,2 with divider busy -> req_rdy_o=0 after two; ids dispatched and written back in order 0,1,2.
REQ-034 mul_vld_i held 1 for 6 cycles while divider result valid, STARVE_MAX=4 -> mul_stall_o=1 after 5th stalled cycle, clears cycle after divider handshake.
REQ-035 flush_i with 2 queued and 1 in flight -> div_flush_o=1, next cycle busy_o=0, no wb_vld_o for any flushed ID.
REQ-036 rst_ni low during D_RUN -> all outputs at REQ-029 values; new request after release completes normally.

Source files
------------

// File: rtl/div_wb_sched_if.sv
// Signal bundle between the issue/divider/multiplier side and the divide
// writeback scheduler. Clock and reset stay as plain ports on the block.
interface div_wb_sched_if #(
    parameter int WIDTH = 64,
    parameter int ID_W  = 3
);
    logic             flush_i;
    logic             req_vld_i;
    logic             req_rdy_o;
    logic [ID_W-1:0]  req_id_i;
    logic [WIDTH-1:0] req_op_a_i;
    logic [WIDTH-1:0] req_op_b_i;
    logic [1:0]       req_opcode_i;
    logic             div_vld_o;
    logic             div_rdy_i;
    logic [ID_W-1:0]  div_id_o;
    logic [WIDTH-1:0] div_op_a_o;
    logic [WIDTH-1:0] div_op_b_o;
    logic [1:0]       div_opcode_o;
    logic             div_flush_o;
    logic             div_out_vld_i;
    logic             div_out_rdy_o;
    logic [ID_W-1:0]  div_id_i;
    logic [WIDTH-1:0] div_res_i;
    logic             mul_vld_i;
    logic [ID_W-1:0]  mul_id_i;
    logic [WIDTH-1:0] mul_res_i;
    logic             wb_vld_o;
    logic [ID_W-1:0]  wb_id_o;
    logic [WIDTH-1:0] wb_res_o;
    logic             mul_stall_o;
    logic             busy_o;

    // Scheduler side
    modport slave (
        input  flush_i, req_vld_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i,
               div_rdy_i, div_out_vld_i, div_id_i, div_res_i,
               mul_vld_i, mul_id_i, mul_res_i,
        output req_rdy_o, div_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
               div_flush_o, div_out_rdy_o, wb_vld_o, wb_id_o, wb_res_o,
               mul_stall_o, busy_o
    );

    // Pipeline / divider / multiplier side
    modport master (
        output flush_i, req_vld_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i,
               div_rdy_i, div_out_vld_i, div_id_i, div_res_i,
               mul_vld_i, mul_id_i, mul_res_i,
        input  req_rdy_o, div_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
               div_flush_o, div_out_rdy_o, wb_vld_o, wb_id_o, wb_res_o,
               mul_stall_o, busy_o
    );
endinterface

// File: rtl/div_wb_sched.sv
// Divide request queue, single-outstanding dispatch to a serial divider, and
// fixed-priority sharing of the writeback port with the multiplier. A divider
// result starved by multiplier traffic eventually raises mul_stall_o.
module div_wb_sched #(
    parameter int WIDTH      = 64,
    parameter int ID_W       = 3,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    div_wb_sched_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [1:0]       opcode;
    } req_t;

    typedef enum logic {D_IDLE, D_RUN} dstate_e;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    dstate_e          state_q, state_d;
    logic [STV_W-1:0] starve_q;
    logic             mul_stall_q;
    logic             wb_vld_q, wb_div_q;
    logic [ID_W-1:0]  wb_id_q;
    logic [WIDTH-1:0] wb_res_q;
    logic             empty, full, req_rdy, enq, deq;
    logic             div_vld, div_out_rdy, div_hs;
    req_t             head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    // No bypass: a full queue refuses even when the head leaves this cycle.
    assign req_rdy = ~full & ~bus.flush_i;
    assign enq     = bus.req_vld_i & req_rdy;
    assign deq     = div_vld & bus.div_rdy_i;
    assign div_hs  = bus.div_out_vld_i & div_out_rdy;
    assign head    = mem[rptr_q];

    // Queue storage; data needs no reset since cnt_q qualifies it.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_q] <= {bus.req_id_i, bus.req_op_a_i, bus.req_op_b_i, bus.req_opcode_i};
    end

    // Queue pointers and occupancy; flush drops everything queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (bus.flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq) wptr_q <= ptr_inc(wptr_q);
            if (deq) rptr_q <= ptr_inc(rptr_q);
            case ({enq, deq})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Dispatch state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= D_IDLE;
        else         state_q <= state_d;
    end

    // Dispatch next-state and handshakes; result is held off while the
    // multiplier owns the writeback port.
    always_comb begin
        state_d     = state_q;
        div_vld     = 1'b0;
        div_out_rdy = 1'b0;
        case (state_q)
            D_IDLE: begin
                div_vld = ~empty & ~bus.flush_i;
                if (div_vld && bus.div_rdy_i) state_d = D_RUN;
            end
            D_RUN: begin
                div_out_rdy = ~bus.mul_vld_i & ~bus.flush_i;
                if (bus.div_out_vld_i && div_out_rdy) state_d = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
        if (bus.flush_i) state_d = D_IDLE;
    end

    // Starvation counter; stall drops the cycle after the result is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q    <= '0;
            mul_stall_q <= 1'b0;
        end else begin
            if (bus.flush_i || div_hs)
                starve_q <= '0;
            else if (state_q == D_RUN && bus.div_out_vld_i && !div_out_rdy && starve_q != STV_MAX)
                starve_q <= starve_q + STV_W'(1);
            mul_stall_q <= (starve_q == STV_MAX) & ~div_hs & ~bus.flush_i;
        end
    end

    // Registered writeback; multiplier wins, flush never blocks it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_vld_q <= 1'b0;
            wb_div_q <= 1'b0;
            wb_id_q  <= '0;
            wb_res_q <= '0;
        end else begin
            wb_vld_q <= bus.mul_vld_i | div_hs;
            wb_div_q <= ~bus.mul_vld_i & div_hs;
            if (bus.mul_vld_i) begin
                wb_id_q  <= bus.mul_id_i;
                wb_res_q <= bus.mul_res_i;
            end else if (div_hs) begin
                wb_id_q  <= bus.div_id_i;
                wb_res_q <= bus.div_res_i;
            end
        end
    end

    assign bus.req_rdy_o     = req_rdy;
    assign bus.div_vld_o     = div_vld;
    assign bus.div_id_o      = head.id;
    assign bus.div_op_a_o    = head.op_a;
    assign bus.div_op_b_o    = head.op_b;
    assign bus.div_opcode_o  = head.opcode;
    assign bus.div_flush_o   = bus.flush_i;
    assign bus.div_out_rdy_o = div_out_rdy;
    assign bus.wb_vld_o      = wb_vld_q;
    assign bus.wb_id_o       = wb_id_q;
    assign bus.wb_res_o      = wb_res_q;
    assign bus.mul_stall_o   = mul_stall_q;
    assign bus.busy_o        = ~empty | (state_q == D_RUN) | (wb_vld_q & wb_div_q);
endmodule
